// File: rtl/ex_stage_pkg.sv
// Shared encodings for the execute stage (mirrors config.v): ALU ops, branch kinds,
// writeback select, the "no register" index, the EX/MEM record and operand forwarding.
package ex_stage_pkg;

  localparam logic [3:0] ALU_ADD  = 4'd0;
  localparam logic [3:0] ALU_SUB  = 4'd1;
  localparam logic [3:0] ALU_AND  = 4'd2;
  localparam logic [3:0] ALU_OR   = 4'd3;
  localparam logic [3:0] ALU_XOR  = 4'd4;
  localparam logic [3:0] ALU_NOT  = 4'd5;
  localparam logic [3:0] ALU_SLL  = 4'd6;
  localparam logic [3:0] ALU_SRL  = 4'd7;
  localparam logic [3:0] ALU_SRA  = 4'd8;
  localparam logic [3:0] ALU_SLT  = 4'd9;
  localparam logic [3:0] ALU_SLTU = 4'd10;
  localparam logic [3:0] ALU_PASSB = 4'd11;
  localparam logic [3:0] ALU_MUL  = 4'd12;
  localparam logic [3:0] ALU_NOP  = 4'd15;

  localparam logic [1:0] BR_NB   = 2'd0;
  localparam logic [1:0] BR_BEQZ = 2'd1;
  localparam logic [1:0] BR_BNEZ = 2'd2;
  localparam logic [1:0] BR_B    = 2'd3;

  localparam logic [1:0] FLAG_ALU  = 2'd0;
  localparam logic [1:0] FLAG_LINK = 2'd1;
  localparam logic [1:0] FLAG_IMM  = 2'd2;
  localparam logic [1:0] FLAG_ALU2 = 2'd3;

  localparam logic [3:0] REG_NONE = 4'hF;

  typedef enum logic [1:0] {MUL_IDLE, MUL_RUN, MUL_DONE} mul_state_t;

  typedef struct packed {
    logic        reg_write;
    logic        mem_to_reg;
    logic        mem_write;
    logic        mem_read;
    logic [3:0]  write_index;
    logic [15:0] result;
    logic [15:0] store_data;
  } exmem_t;

  // Reset value and stall bubble share one encoding: no side effects, no destination.
  localparam exmem_t EXMEM_BUBBLE = '{reg_write: 1'b0, mem_to_reg: 1'b0, mem_write: 1'b0,
                                      mem_read: 1'b0, write_index: REG_NONE,
                                      result: 16'h0, store_data: 16'h0};

  // The youngest producer wins: MEM over WB over the register file.
  function automatic logic [15:0] forward_operand(
    input logic [3:0]  read_index,
    input logic [15:0] reg_data,
    input logic        mem_write,
    input logic [3:0]  mem_index,
    input logic [15:0] mem_data,
    input logic        wb_write,
    input logic [3:0]  wb_index,
    input logic [15:0] wb_data
  );
    if (read_index == REG_NONE)                        return reg_data;
    else if (mem_write && (mem_index == read_index))   return mem_data;
    else if (wb_write && (wb_index == read_index))     return wb_data;
    else                                               return reg_data;
  endfunction

endpackage

// File: rtl/ex_stage_mul.sv
// ex_mul: iterative shift-add multiplier, one partial product per cycle over 16 cycles.
// Only instantiated when EX_MUL_EN is defined.
module ex_mul
  import ex_stage_pkg::*;
(
  input  logic        Clk,
  input  logic        Rst,
  input  logic        start,
  input  logic [15:0] a,
  input  logic [15:0] b,
  output logic        busy,
  output logic        done,
  output logic [15:0] product
);

  mul_state_t  state, state_next;
  logic [15:0] a_q, b_q, acc;
  logic [3:0]  count;

  always_ff @(posedge Clk or negedge Rst) begin
    if (!Rst) state <= MUL_IDLE;
    else      state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      MUL_IDLE: if (start) state_next = MUL_RUN;
      MUL_RUN:  if (count == 4'd15) state_next = MUL_DONE;
      MUL_DONE: state_next = MUL_IDLE;
      default:  state_next = MUL_IDLE;
    endcase
  end

  // Busy covers the launch cycle too, so the front end freezes before operands latch.
  always_comb begin
    busy = ((state == MUL_IDLE) && start) || (state == MUL_RUN);
    done = (state == MUL_DONE);
  end

  always_ff @(posedge Clk or negedge Rst) begin
    if (!Rst) begin
      a_q   <= 16'h0;
      b_q   <= 16'h0;
      acc   <= 16'h0;
      count <= 4'd0;
    end else if ((state == MUL_IDLE) && start) begin
      a_q   <= a;
      b_q   <= b;
      acc   <= 16'h0;
      count <= 4'd0;
    end else if (state == MUL_RUN) begin
      if (b_q[count]) acc <= acc + (a_q << count);
      count <= count + 4'd1;
    end
  end

  assign product = acc;

endmodule

// File: rtl/ex_stage.sv
// Execute stage: forwarding, ALU, branch/jump resolution and the EX/MEM register.
// Define EX_MUL_EN to build the iterative multiplier; otherwise MUL yields 0 and Stall is 0.
module ex_stage
  import ex_stage_pkg::*;
(
  input  logic        Clk,
  input  logic        Rst,
  input  logic        RegWrite,
  input  logic        MemotoReg,
  input  logic        MemWrite,
  input  logic        MemRead,
  input  logic [3:0]  AluOp,
  input  logic [15:0] PcAddr,
  input  logic [15:0] RegData1,
  input  logic [15:0] RegData2,
  input  logic [1:0]  Flag,
  input  logic [3:0]  RegWriteIndex,
  input  logic [3:0]  RegReadIndex1,
  input  logic [3:0]  RegReadIndex2,
  input  logic        InsJ,
  input  logic [1:0]  InsB,
  input  logic        AluSrc,
  input  logic [15:0] Dest,
  input  logic        MemFwdWrite,
  input  logic [3:0]  MemFwdIndex,
  input  logic [15:0] MemFwdData,
  input  logic        WbFwdWrite,
  input  logic [3:0]  WbFwdIndex,
  input  logic [15:0] WbFwdData,
  output logic        RegWrite2,
  output logic        MemotoReg2,
  output logic        MemWrite2,
  output logic        MemRead2,
  output logic [15:0] AluResult2,
  output logic [15:0] StoreData2,
  output logic [3:0]  RegWriteIndex2,
  output logic        Flush,
  output logic [15:0] Target,
  output logic        Stall
);

  logic [15:0] op_a, op_b_fwd, op_b, alu_result, result;
  logic        take_branch, flush_raw;
  logic        mul_busy, mul_done;
  logic [15:0] mul_product;
  exmem_t      ex_mem_q, ex_mem_next;

  assign op_a = forward_operand(RegReadIndex1, RegData1, MemFwdWrite, MemFwdIndex, MemFwdData,
                                WbFwdWrite, WbFwdIndex, WbFwdData);
  assign op_b_fwd = forward_operand(RegReadIndex2, RegData2, MemFwdWrite, MemFwdIndex, MemFwdData,
                                    WbFwdWrite, WbFwdIndex, WbFwdData);
  assign op_b = AluSrc ? Dest : op_b_fwd;

`ifdef EX_MUL_EN
  ex_mul u_mul (
    .Clk     (Clk),
    .Rst     (Rst),
    .start   (AluOp == ALU_MUL),
    .a       (op_a),
    .b       (op_b),
    .busy    (mul_busy),
    .done    (mul_done),
    .product (mul_product)
  );
`else
  assign mul_busy    = 1'b0;
  assign mul_done    = 1'b0;
  assign mul_product = 16'h0;
`endif

  always_comb begin
    alu_result = 16'h0;
    case (AluOp)
      ALU_ADD:   alu_result = op_a + op_b;
      ALU_SUB:   alu_result = op_a - op_b;
      ALU_AND:   alu_result = op_a & op_b;
      ALU_OR:    alu_result = op_a | op_b;
      ALU_XOR:   alu_result = op_a ^ op_b;
      ALU_NOT:   alu_result = ~op_a;
      ALU_SLL:   alu_result = op_a << op_b[3:0];
      ALU_SRL:   alu_result = op_a >> op_b[3:0];
      ALU_SRA:   alu_result = 16'($signed(op_a) >>> op_b[3:0]);
      ALU_SLT:   alu_result = {15'h0, $signed(op_a) < $signed(op_b)};
      ALU_SLTU:  alu_result = {15'h0, op_a < op_b};
      ALU_PASSB: alu_result = op_b;
      ALU_MUL:   alu_result = mul_done ? mul_product : 16'h0;
      ALU_NOP:   alu_result = 16'h0;
      default:   alu_result = 16'h0;
    endcase
  end

  always_comb begin
    result = alu_result;
    case (Flag)
      FLAG_ALU:  result = alu_result;
      FLAG_LINK: result = PcAddr;
      FLAG_IMM:  result = Dest;
      FLAG_ALU2: result = alu_result;
      default:   result = alu_result;
    endcase
  end

  // Jump-register overrides any branch; both redirect in the cycle they sit in EX.
  always_comb begin
    take_branch = 1'b0;
    case (InsB)
      BR_NB:   take_branch = 1'b0;
      BR_BEQZ: take_branch = (op_a == 16'h0);
      BR_BNEZ: take_branch = (op_a != 16'h0);
      BR_B:    take_branch = 1'b1;
      default: take_branch = 1'b0;
    endcase
    if (InsJ) begin
      flush_raw = 1'b1;
      Target    = op_a;
    end else begin
      flush_raw = take_branch;
      Target    = PcAddr + Dest;
    end
  end

  assign Flush = flush_raw & Rst;
  assign Stall = mul_busy & Rst;

  always_comb begin
    ex_mem_next = '{reg_write: RegWrite, mem_to_reg: MemotoReg, mem_write: MemWrite,
                    mem_read: MemRead, write_index: RegWriteIndex,
                    result: result, store_data: op_b_fwd};
    if (Stall) ex_mem_next = EXMEM_BUBBLE;
  end

  always_ff @(posedge Clk or negedge Rst) begin
    if (!Rst) ex_mem_q <= EXMEM_BUBBLE;
    else      ex_mem_q <= ex_mem_next;
  end

  assign RegWrite2      = ex_mem_q.reg_write;
  assign MemotoReg2     = ex_mem_q.mem_to_reg;
  assign MemWrite2      = ex_mem_q.mem_write;
  assign MemRead2       = ex_mem_q.mem_read;
  assign RegWriteIndex2 = ex_mem_q.write_index;
  assign AluResult2     = ex_mem_q.result;
  assign StoreData2     = ex_mem_q.store_data;

endmodule

// File: tb/tb_ex_stage.sv
// Self-checking bench for ex_stage: directed scenarios plus randomized back-to-back traffic
// against a behavioural model; multiplier scenarios follow EX_MUL_EN.
module tb_ex_stage;

  logic        Clk = 1'b0;
  logic        Rst = 1'b0;
  logic        RegWrite, MemotoReg, MemWrite, MemRead;
  logic [3:0]  AluOp;
  logic [15:0] PcAddr, RegData1, RegData2;
  logic [1:0]  Flag;
  logic [3:0]  RegWriteIndex, RegReadIndex1, RegReadIndex2;
  logic        InsJ;
  logic [1:0]  InsB;
  logic        AluSrc;
  logic [15:0] Dest;
  logic        MemFwdWrite;
  logic [3:0]  MemFwdIndex;
  logic [15:0] MemFwdData;
  logic        WbFwdWrite;
  logic [3:0]  WbFwdIndex;
  logic [15:0] WbFwdData;
  logic        RegWrite2, MemotoReg2, MemWrite2, MemRead2;
  logic [15:0] AluResult2, StoreData2;
  logic [3:0]  RegWriteIndex2;
  logic        Flush;
  logic [15:0] Target;
  logic        Stall;

  int vectors = 0;
  int miscompares = 0;

  always #5 Clk = ~Clk;

  ex_stage dut (
    .Clk(Clk), .Rst(Rst),
    .RegWrite(RegWrite), .MemotoReg(MemotoReg), .MemWrite(MemWrite), .MemRead(MemRead),
    .AluOp(AluOp), .PcAddr(PcAddr), .RegData1(RegData1), .RegData2(RegData2), .Flag(Flag),
    .RegWriteIndex(RegWriteIndex), .RegReadIndex1(RegReadIndex1), .RegReadIndex2(RegReadIndex2),
    .InsJ(InsJ), .InsB(InsB), .AluSrc(AluSrc), .Dest(Dest),
    .MemFwdWrite(MemFwdWrite), .MemFwdIndex(MemFwdIndex), .MemFwdData(MemFwdData),
    .WbFwdWrite(WbFwdWrite), .WbFwdIndex(WbFwdIndex), .WbFwdData(WbFwdData),
    .RegWrite2(RegWrite2), .MemotoReg2(MemotoReg2), .MemWrite2(MemWrite2), .MemRead2(MemRead2),
    .AluResult2(AluResult2), .StoreData2(StoreData2), .RegWriteIndex2(RegWriteIndex2),
    .Flush(Flush), .Target(Target), .Stall(Stall)
  );

  // Reference model: operand selection and ALU semantics written from the ISA rules.
  function automatic logic [15:0] ref_forward(input logic [3:0] idx, input logic [15:0] rf);
    if (idx == 4'hF) return rf;
    if (MemFwdWrite && MemFwdIndex == idx) return MemFwdData;
    if (WbFwdWrite && WbFwdIndex == idx) return WbFwdData;
    return rf;
  endfunction

  function automatic logic [15:0] ref_alu(input logic [3:0] op, input logic [15:0] a,
                                          input logic [15:0] b);
    logic signed [15:0] sa, sb;
    int unsigned sh;
    sa = a;
    sb = b;
    sh = int'(b[3:0]);
    case (op)
      4'd0:  return a + b;
      4'd1:  return a - b;
      4'd2:  return a & b;
      4'd3:  return a | b;
      4'd4:  return a ^ b;
      4'd5:  return ~a;
      4'd6:  return 16'(32'(a) * (32'd1 << sh));
      4'd7:  return 16'(32'(a) / (32'd1 << sh));
      4'd8:  return sa >>> sh;
      4'd9:  return (sa < sb) ? 16'd1 : 16'd0;
      4'd10: return (a < b) ? 16'd1 : 16'd0;
      4'd11: return b;
`ifdef EX_MUL_EN
      4'd12: return 16'(32'(a) * 32'(b));
`endif
      default: return 16'h0;
    endcase
  endfunction

  function automatic logic [3:0] pick_index();
    int r;
    r = $urandom_range(0, 4);
    return (r == 4) ? 4'hF : 4'(r);
  endfunction

  task automatic apply_idle();
    RegWrite = 0; MemotoReg = 0; MemWrite = 0; MemRead = 0;
    AluOp = 4'd15; PcAddr = 16'h0; RegData1 = 16'h0; RegData2 = 16'h0; Flag = 2'd0;
    RegWriteIndex = 4'hF; RegReadIndex1 = 4'hF; RegReadIndex2 = 4'hF;
    InsJ = 0; InsB = 2'd0; AluSrc = 0; Dest = 16'h0;
    MemFwdWrite = 0; MemFwdIndex = 4'hF; MemFwdData = 16'h0;
    WbFwdWrite = 0; WbFwdIndex = 4'hF; WbFwdData = 16'h0;
  endtask

  task automatic test_reset();
    apply_idle();
    InsJ = 1; AluOp = 4'd12; RegWrite = 1; RegWriteIndex = 4'd3;
    Rst = 0;
    repeat (3) @(posedge Clk);
    #1;
    vectors++;
    if ({RegWrite2, MemotoReg2, MemWrite2, MemRead2, RegWriteIndex2, AluResult2, StoreData2}
        !== {4'b0000, 4'hF, 16'h0, 16'h0}) begin
      miscompares++;
      $display("[TB] FAIL reset_regs: got %h %h %h required 0f 0000 0000",
               {RegWrite2, MemotoReg2, MemWrite2, MemRead2, RegWriteIndex2}, AluResult2, StoreData2);
    end
    vectors++;
    if ({Flush, Stall} !== 2'b00) begin
      miscompares++;
      $display("[TB] FAIL reset_flush_stall: got %b required 00", {Flush, Stall});
    end
    apply_idle();
    @(negedge Clk);
    Rst = 1;
    @(posedge Clk);
    #1;
  endtask

  task automatic test_forward_priority();
    apply_idle();
    AluOp = 4'd0; RegReadIndex1 = 4'd3; RegData1 = 16'h0; AluSrc = 1; Dest = 16'h0001;
    MemFwdWrite = 1; MemFwdIndex = 4'd3; MemFwdData = 16'h0011;
    WbFwdWrite = 1; WbFwdIndex = 4'd3; WbFwdData = 16'h0022;
    RegWrite = 1; RegWriteIndex = 4'd4;
    @(posedge Clk);
    #1;
    vectors++;
    if ({RegWrite2, RegWriteIndex2, AluResult2} !== {1'b1, 4'd4, 16'h0012}) begin
      miscompares++;
      $display("[TB] FAIL fwd_priority: got %b %h %h required 1 4 0012",
               RegWrite2, RegWriteIndex2, AluResult2);
    end
  endtask

  task automatic test_branch();
    apply_idle();
    InsB = 2'd2; RegReadIndex1 = 4'd2; RegData1 = 16'h0;
    WbFwdWrite = 1; WbFwdIndex = 4'd2; WbFwdData = 16'h0005;
    PcAddr = 16'h0040; Dest = 16'hFFFE;
    #1;
    vectors++;
    if ({Flush, Target} !== {1'b1, 16'h003E}) begin
      miscompares++;
      $display("[TB] FAIL bnez_taken: got %b %h required 1 003e", Flush, Target);
    end
    InsB = 2'd1;
    #1;
    vectors++;
    if (Flush !== 1'b0) begin
      miscompares++;
      $display("[TB] FAIL beqz_not_taken: got %b required 0", Flush);
    end
    @(posedge Clk);
    #1;
  endtask

  task automatic test_jump_link();
    apply_idle();
    InsJ = 1; InsB = 2'd1; Flag = 2'd1; RegReadIndex1 = 4'd6; RegData1 = 16'h1234;
    PcAddr = 16'h0008; RegWrite = 1; RegWriteIndex = 4'd14;
    #1;
    vectors++;
    if ({Flush, Target} !== {1'b1, 16'h1234}) begin
      miscompares++;
      $display("[TB] FAIL jump_target: got %b %h required 1 1234", Flush, Target);
    end
    @(posedge Clk);
    #1;
    vectors++;
    if ({RegWriteIndex2, AluResult2} !== {4'd14, 16'h0008}) begin
      miscompares++;
      $display("[TB] FAIL jump_link: got %h %h required e 0008", RegWriteIndex2, AluResult2);
    end
  endtask

  task automatic test_random_back_to_back(input int n);
    logic [15:0] a, bf, b, exp_res, exp_tgt;
    logic        exp_flush;
    logic [7:0]  exp_ctrl;
    for (int i = 0; i < n; i++) begin
      RegWrite = 1'($urandom); MemotoReg = 1'($urandom);
      MemWrite = 1'($urandom); MemRead = 1'($urandom);
      AluOp = 4'($urandom);
`ifdef EX_MUL_EN
      if (AluOp == 4'd12) AluOp = 4'd0;
`endif
      PcAddr = 16'($urandom);
      RegData1 = ($urandom_range(0, 3) == 0) ? 16'h0 : 16'($urandom);
      RegData2 = 16'($urandom);
      Flag = 2'($urandom);
      RegWriteIndex = 4'($urandom);
      RegReadIndex1 = pick_index(); RegReadIndex2 = pick_index();
      InsJ = ($urandom_range(0, 5) == 0); InsB = 2'($urandom); AluSrc = 1'($urandom);
      Dest = ($urandom_range(0, 1) == 0) ? 16'($urandom_range(0, 15)) : 16'($urandom);
      MemFwdWrite = 1'($urandom); MemFwdIndex = pick_index(); MemFwdData = 16'($urandom);
      WbFwdWrite = 1'($urandom); WbFwdIndex = pick_index();
      WbFwdData = ($urandom_range(0, 3) == 0) ? 16'h0 : 16'($urandom);
      #1;
      a  = ref_forward(RegReadIndex1, RegData1);
      bf = ref_forward(RegReadIndex2, RegData2);
      b  = AluSrc ? Dest : bf;
      exp_flush = InsJ || (InsB == 2'd3) || (InsB == 2'd1 && a == 16'h0) ||
                  (InsB == 2'd2 && a != 16'h0);
      exp_tgt = InsJ ? a : PcAddr + Dest;
      exp_res = (Flag == 2'd1) ? PcAddr : (Flag == 2'd2) ? Dest : ref_alu(AluOp, a, b);
      exp_ctrl = {RegWrite, MemotoReg, MemWrite, MemRead, RegWriteIndex};
      vectors++;
      if ({Flush, Stall} !== {exp_flush, 1'b0}) begin
        miscompares++;
        $display("[TB] FAIL rand_flush_stall[%0d]: got %b required %b", i, {Flush, Stall},
                 {exp_flush, 1'b0});
      end
      if (exp_flush) begin
        vectors++;
        if (Target !== exp_tgt) begin
          miscompares++;
          $display("[TB] FAIL rand_target[%0d]: got %h required %h", i, Target, exp_tgt);
        end
      end
      @(posedge Clk);
      #1;
      vectors++;
      if ({RegWrite2, MemotoReg2, MemWrite2, MemRead2, RegWriteIndex2, AluResult2, StoreData2}
          !== {exp_ctrl, exp_res, bf}) begin
        miscompares++;
        $display("[TB] FAIL rand_exmem[%0d] op=%0d: got %h %h %h required %h %h %h", i, AluOp,
                 {RegWrite2, MemotoReg2, MemWrite2, MemRead2, RegWriteIndex2}, AluResult2,
                 StoreData2, exp_ctrl, exp_res, bf);
      end
    end
  endtask

`ifdef EX_MUL_EN
  task automatic run_mul(input logic [15:0] a, input logic [15:0] b);
    int n;
    logic [15:0] exp_prod;
    apply_idle();
    AluOp = 4'd12; RegData1 = a; RegData2 = b; RegReadIndex1 = 4'd1; RegReadIndex2 = 4'd2;
    RegWrite = 1; RegWriteIndex = 4'd7; Dest = 16'hBEEF;
    exp_prod = 16'(32'(a) * 32'(b));
    #1;
    n = 0;
    while (Stall === 1'b1 && n < 40) begin
      n++;
      @(posedge Clk);
      #1;
      vectors++;
      if ({RegWrite2, MemotoReg2, MemWrite2, MemRead2, RegWriteIndex2} !== 8'h0F) begin
        miscompares++;
        $display("[TB] FAIL mul_bubble[%0d]: got %h required 0f", n,
                 {RegWrite2, MemotoReg2, MemWrite2, MemRead2, RegWriteIndex2});
      end
      // Forwarding sources shift under a stalled MUL; the latched operands must win.
      MemFwdWrite = 1; MemFwdIndex = 4'd1; MemFwdData = 16'($urandom);
      WbFwdWrite = 1; WbFwdIndex = 4'd2; WbFwdData = 16'($urandom);
      #1;
    end
    vectors++;
    if (n != 17) begin
      miscompares++;
      $display("[TB] FAIL mul_stall_cycles: got %0d required 17", n);
    end
    @(posedge Clk);
    #1;
    vectors++;
    if ({RegWrite2, RegWriteIndex2, AluResult2} !== {1'b1, 4'd7, exp_prod}) begin
      miscompares++;
      $display("[TB] FAIL mul_result %h*%h: got %b %h %h required 1 7 %h", a, b, RegWrite2,
               RegWriteIndex2, AluResult2, exp_prod);
    end
    apply_idle();
    #1;
  endtask

  task automatic test_mul();
    run_mul(16'h0123, 16'h0045);
    for (int i = 0; i < 3; i++) run_mul(16'($urandom), 16'($urandom));
  endtask

  task automatic test_mul_reset();
    apply_idle();
    AluOp = 4'd12; RegData1 = 16'h7777; RegData2 = 16'h0003; RegWrite = 1; RegWriteIndex = 4'd9;
    repeat (5) @(posedge Clk);
    #1;
    Rst = 0;
    #1;
    vectors++;
    if ({Stall, RegWrite2, RegWriteIndex2} !== {1'b0, 1'b0, 4'hF}) begin
      miscompares++;
      $display("[TB] FAIL mul_reset: got %b %b %h required 0 0 f", Stall, RegWrite2,
               RegWriteIndex2);
    end
    @(negedge Clk);
    Rst = 1;
    run_mul(16'h00FF, 16'h0101);
  endtask
`else
  task automatic test_mul_disabled();
    for (int i = 0; i < 3; i++) begin
      apply_idle();
      AluOp = 4'd12; RegData1 = 16'($urandom) | 16'h1; RegData2 = 16'($urandom) | 16'h1;
      RegReadIndex1 = 4'd1; RegReadIndex2 = 4'd2; RegWrite = 1; RegWriteIndex = 4'd7;
      #1;
      vectors++;
      if (Stall !== 1'b0) begin
        miscompares++;
        $display("[TB] FAIL mul_off_stall[%0d]: got %b required 0", i, Stall);
      end
      @(posedge Clk);
      #1;
      vectors++;
      if ({RegWrite2, RegWriteIndex2, AluResult2} !== {1'b1, 4'd7, 16'h0}) begin
        miscompares++;
        $display("[TB] FAIL mul_off_result[%0d]: got %b %h %h required 1 7 0000", i,
                 RegWrite2, RegWriteIndex2, AluResult2);
      end
    end
  endtask
`endif

  initial begin
    #2000000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    test_reset();
    test_forward_priority();
    test_branch();
    test_jump_link();
    test_random_back_to_back(200);
`ifdef EX_MUL_EN
    test_mul();
    test_mul_reset();
`else
    test_mul_disabled();
`endif
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
